// File: rtl/signal_arbiter_pkg.sv
// Shared constants and the round-robin grant helper for signal_arbiter.
// The grant helper searches at most MAX_CHANNELS requesters starting at a pointer.
package signal_arbiter_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DEPTH    = 4;
  localparam int DROP_CNT_W   = 16;
  localparam int MAX_CHANNELS = 16;

  // Returns {found, index}: first set bit of req at or after ptr, wrapping at n-1.
  function automatic logic [4:0] rr_grant(input logic [MAX_CHANNELS-1:0] req,
                                          input logic [3:0]              ptr,
                                          input int                      n);
    logic [4:0] res;
    int         idx;
    res = '0;
    idx = 0;
    // Walk downward so the lowest offset from ptr is the last (winning) assignment.
    for (int k = MAX_CHANNELS - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[3:0]]) res = {1'b1, idx[3:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/signal_fifo.sv
// Per-channel FIFO: DEPTH words, registered read port, pointer-based full/empty.
// A write while full is accepted only when a read happens in the same cycle.
module signal_fifo
  import signal_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic [WIDTH-1:0] rd_data_reg;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (wr_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_ok) rd_ptr_next = rd_ptr_reg + 1'b1;
  end

  // Storage carries no reset so it maps onto block RAM; pointers define validity.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rd_data_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      // Read-before-write: a full FIFO read and written together returns the old head.
      if (rd_ok) rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/signal_arbiter.sv
// Round-robin arbiter merging CHANNELS buffered input streams onto one registered output.
// Optional feature: define SIGNAL_ARBITER_DROP_CNT_EN to add per-channel DROP_CNT counters.
module signal_arbiter
  import signal_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [CHANNELS*WIDTH-1:0]   IN_VALUE,
  input  logic [CHANNELS-1:0]         IN_VALID,
  output logic [WIDTH-1:0]            OUT_VALUE,
  output logic                        OUT_VALID,
  output logic [$clog2(CHANNELS)-1:0] OUT_CHANNEL,
  output logic [CHANNELS-1:0]         OVERFLOW,
  input  logic [CHANNELS-1:0]         OVERFLOW_CLEAR
`ifdef SIGNAL_ARBITER_DROP_CNT_EN
  ,
  output logic [CHANNELS*DROP_CNT_W-1:0] DROP_CNT
`endif
);

  localparam int CW = $clog2(CHANNELS);

  logic [CHANNELS-1:0] fifo_full;
  logic [CHANNELS-1:0] fifo_empty;
  logic [CHANNELS-1:0] rd_en;
  logic [CHANNELS-1:0] drop;
  logic [WIDTH-1:0]    rd_data [CHANNELS];

  logic [4:0]          grant;
  logic                grant_vld;
  logic [CW-1:0]       grant_idx;

  logic [CW-1:0]       ptr_reg, ptr_next;
  logic [CW-1:0]       out_channel_reg, out_channel_next;
  logic                out_valid_reg, out_valid_next;
  logic [CHANNELS-1:0] overflow_reg, overflow_next;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_fifo
      signal_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .wr_en   (IN_VALID[gi]),
        .wr_data (IN_VALUE[gi*WIDTH +: WIDTH]),
        .rd_en   (rd_en[gi]),
        .rd_data (rd_data[gi]),
        .full    (fifo_full[gi]),
        .empty   (fifo_empty[gi])
      );
    end
  endgenerate

  // Grants look only at registered FIFO occupancy, so same-cycle writes cannot be granted.
  always_comb begin
    grant            = rr_grant(MAX_CHANNELS'(~fifo_empty), 4'(ptr_reg), CHANNELS);
    grant_vld        = grant[4];
    grant_idx        = CW'(grant[3:0]);
    rd_en            = '0;
    ptr_next         = ptr_reg;
    out_channel_next = out_channel_reg;
    out_valid_next   = grant_vld;
    if (grant_vld) begin
      rd_en[grant_idx] = 1'b1;
      out_channel_next = grant_idx;
      ptr_next         = (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end
    drop          = IN_VALID & fifo_full & ~rd_en;
    overflow_next = drop | (overflow_reg & ~OVERFLOW_CLEAR);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr_reg         <= '0;
      out_channel_reg <= '0;
      out_valid_reg   <= 1'b0;
      overflow_reg    <= '0;
    end else begin
      ptr_reg         <= ptr_next;
      out_channel_reg <= out_channel_next;
      out_valid_reg   <= out_valid_next;
      overflow_reg    <= overflow_next;
    end
  end

  // The granted FIFO's read register holds the word; it only changes on that channel's next grant.
  assign OUT_VALUE   = rd_data[out_channel_reg];
  assign OUT_VALID   = out_valid_reg;
  assign OUT_CHANNEL = out_channel_reg;
  assign OVERFLOW    = overflow_reg;

`ifdef SIGNAL_ARBITER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_reg [CHANNELS];

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_drop_cnt
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          drop_cnt_reg[gi] <= '0;
        end else if (OVERFLOW_CLEAR[gi]) begin
          drop_cnt_reg[gi] <= '0;
        end else if (drop[gi] && (drop_cnt_reg[gi] != '1)) begin
          drop_cnt_reg[gi] <= drop_cnt_reg[gi] + 1'b1;
        end
      end
      assign DROP_CNT[gi*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_reg[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_signal_arbiter.sv
// Self-checking bench for signal_arbiter: fixed vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_signal_arbiter;

  localparam int WIDTH = 32;
  localparam int CH    = 4;
  localparam int DEPTH = 4;

  logic           CLK;
  logic           RESET;
  logic [127:0]   IN_VALUE;
  logic [3:0]     IN_VALID;
  logic [31:0]    OUT_VALUE;
  logic           OUT_VALID;
  logic [1:0]     OUT_CHANNEL;
  logic [3:0]     OVERFLOW;
  logic [3:0]     OVERFLOW_CLEAR;
`ifdef SIGNAL_ARBITER_DROP_CNT_EN
  logic [63:0]    DROP_CNT;
`endif

  signal_arbiter #(.WIDTH(WIDTH), .CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .IN_VALUE       (IN_VALUE),
    .IN_VALID       (IN_VALID),
    .OUT_VALUE      (OUT_VALUE),
    .OUT_VALID      (OUT_VALID),
    .OUT_CHANNEL    (OUT_CHANNEL),
    .OVERFLOW       (OVERFLOW),
    .OVERFLOW_CLEAR (OVERFLOW_CLEAR)
`ifdef SIGNAL_ARBITER_DROP_CNT_EN
    ,
    .DROP_CNT       (DROP_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] q [CH][$];
  int          m_ptr;
  logic        e_valid;
  logic [31:0] e_value;
  logic [1:0]  e_ch;
  logic [3:0]  e_ovf;
  int          m_cnt [CH];
  logic [3:0]  m_last_drop;

  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin
      q[i].delete();
      m_cnt[i] = 0;
    end
    m_ptr = 0; e_valid = 0; e_value = 0; e_ch = 0; e_ovf = 0; m_last_drop = 0;
  endtask

  function automatic int peek_grant();
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (m_ptr + k) % CH;
      if (q[c].size() > 0) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] v, input logic [127:0] d, input logic [3:0] clr);
    int g;
    g = peek_grant();
    if (g >= 0) begin
      e_valid = 1'b1;
      e_value = q[g].pop_front();
      e_ch    = 2'(g);
      m_ptr   = (g + 1) % CH;
    end else begin
      e_valid = 1'b0;
    end
    for (int i = 0; i < CH; i++) begin
      logic dr;
      dr = 1'b0;
      if (v[i]) begin
        if (q[i].size() < DEPTH) q[i].push_back(d[i*32 +: 32]);
        else dr = 1'b1;
      end
      m_last_drop[i] = dr;
      e_ovf[i] = dr | (e_ovf[i] & ~clr[i]);
      if (clr[i]) m_cnt[i] = 0;
      else if (dr && m_cnt[i] < 65535) m_cnt[i]++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_edge(input logic [3:0] v, input logic [127:0] d, input logic [3:0] clr);
    IN_VALID = v; IN_VALUE = d; OVERFLOW_CLEAR = clr;
    model_step(v, d, clr);
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input logic [3:0] v, input logic [127:0] d, input logic [3:0] clr);
    @(negedge CLK);
    drive_edge(v, d, clr);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, 32'(OUT_VALID), 32'(e_valid));
    chk({tag, ".value"}, OUT_VALUE, e_value);
    chk({tag, ".chan"},  32'(OUT_CHANNEL), 32'(e_ch));
    chk({tag, ".ovf"},   32'(OVERFLOW), 32'(e_ovf));
`ifdef SIGNAL_ARBITER_DROP_CNT_EN
    for (int i = 0; i < CH; i++)
      chk($sformatf("%s.dropcnt%0d", tag, i), 32'(DROP_CNT[i*16 +: 16]), 32'(m_cnt[i]));
`endif
  endtask

  task automatic cyc_chk(input string tag, input logic [3:0] v, input logic [127:0] d,
                         input logic [3:0] clr);
    cyc(v, d, clr);
    cmp_model(tag);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; IN_VALID = 0; IN_VALUE = 0; OVERFLOW_CLEAR = 0;
    m_reset();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] e);
    return {e, c, b, a};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]   v;
    logic [127:0] d;
    logic [3:0]   clr;
    logic         x_valid;
    logic [31:0]  x_value;
    logic [1:0]   x_ch;
    logic [3:0]   x_ovf;
  } vec_t;

  vec_t tbl [9];

  int          fwr_hits;
  int          outs;
  int          seq [CH];
  logic [3:0]  vv;
  logic [127:0] dd;
  int          g;
  logic        seen_drop;

  initial begin
    RESET = 1'b1; IN_VALID = 0; IN_VALUE = 0; OVERFLOW_CLEAR = 0;
    m_reset();

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.valid", 32'(OUT_VALID), 0);
    chk("rst.value", OUT_VALUE, 0);
    chk("rst.chan",  32'(OUT_CHANNEL), 0);
    chk("rst.ovf",   32'(OVERFLOW), 0);
    @(negedge CLK);
    RESET = 1'b0;

    // Single-channel latency, hold behaviour, then round-robin from the updated pointer
    tbl[0] = '{4'b0100, pack4(0, 0, 32'hA5A5_0001, 0), 4'b0, 1'b0, 32'h0,          2'd0, 4'b0};
    tbl[1] = '{4'b0000, 128'h0,                         4'b0, 1'b1, 32'hA5A5_0001, 2'd2, 4'b0};
    tbl[2] = '{4'b0000, 128'h0,                         4'b0, 1'b0, 32'hA5A5_0001, 2'd2, 4'b0};
    tbl[3] = '{4'b1111, pack4(32'h10, 32'h11, 32'h12, 32'h13), 4'b0, 1'b0, 32'hA5A5_0001, 2'd2, 4'b0};
    tbl[4] = '{4'b0000, 128'h0,                         4'b0, 1'b1, 32'h13,        2'd3, 4'b0};
    tbl[5] = '{4'b0000, 128'h0,                         4'b0, 1'b1, 32'h10,        2'd0, 4'b0};
    tbl[6] = '{4'b0000, 128'h0,                         4'b0, 1'b1, 32'h11,        2'd1, 4'b0};
    tbl[7] = '{4'b0000, 128'h0,                         4'b0, 1'b1, 32'h12,        2'd2, 4'b0};
    tbl[8] = '{4'b0000, 128'h0,                         4'b0, 1'b0, 32'h12,        2'd2, 4'b0};
    for (int r = 0; r < 9; r++) begin
      cyc(tbl[r].v, tbl[r].d, tbl[r].clr);
      chk($sformatf("tbl%0d.valid", r), 32'(OUT_VALID), 32'(tbl[r].x_valid));
      chk($sformatf("tbl%0d.value", r), OUT_VALUE, tbl[r].x_value);
      chk($sformatf("tbl%0d.chan", r),  32'(OUT_CHANNEL), 32'(tbl[r].x_ch));
      chk($sformatf("tbl%0d.ovf", r),   32'(OVERFLOW), 32'(tbl[r].x_ovf));
    end

    // Fairness: sources keep every FIFO non-empty without ever overfilling it
    do_reset();
    outs = 0;
    for (int i = 0; i < CH; i++) seq[i] = 0;
    for (int c = 0; c < 40; c++) begin
      vv = 0; dd = 0;
      for (int i = 0; i < CH; i++) begin
        if (q[i].size() < DEPTH) begin
          vv[i] = 1'b1;
          dd[i*32 +: 32] = 32'((i << 16) | seq[i]);
          seq[i]++;
        end
      end
      cyc_chk("fair", vv, dd, 4'b0);
      if (OUT_VALID) begin
        chk("fair.order", 32'(OUT_CHANNEL), 32'(outs % CH));
        outs++;
      end
    end
    chk("fair.ovf_clean", 32'(OVERFLOW), 0);

    // Overflow: channel 1 sends 12 words back-to-back against three busy neighbours
    do_reset();
    for (int c = 0; c < 16; c++) begin
      vv = (c < 12) ? 4'b1111 : 4'b1101;
      dd = pack4(32'(32'h0000_0100 + c), 32'(32'h0001_0100 + c),
                 32'(32'h0002_0100 + c), 32'(32'h0003_0100 + c));
      cyc_chk("ovfl", vv, dd, 4'b0);
    end
    chk("ovfl.flag1", 32'(OVERFLOW[1]), 1);

    // Clear collision on channel 3: keep traffic flowing until a drop lands with the clear
    seen_drop = 1'b0;
    for (int c = 0; c < 8 && !seen_drop; c++) begin
      g = peek_grant();
      dd = pack4(32'h0000_0200 + 32'(c), 32'h0001_0200 + 32'(c),
                 32'h0002_0200 + 32'(c), 32'h0003_0200 + 32'(c));
      if (q[3].size() == DEPTH && g != 3) begin
        cyc_chk("coll", 4'b1111, dd, 4'b1000);
        chk("coll.ovf3_kept", 32'(OVERFLOW[3]), 1);
        seen_drop = 1'b1;
      end else begin
        cyc_chk("coll_pre", 4'b1111, dd, 4'b0);
      end
    end
    chk("coll.reached", 32'(seen_drop), 1);
    cyc_chk("clr_alone", 4'b0000, 128'h0, 4'b1000);
    chk("clr_alone.ovf3", 32'(OVERFLOW[3]), 0);
    repeat (16) cyc_chk("drain", 4'b0000, 128'h0, 4'b0);

    // Full FIFO 0 written in its grant cycle must not drop
    do_reset();
    fwr_hits = 0;
    for (int c = 0; c < 24; c++) begin
      g = peek_grant();
      vv = 4'b0010;
      if (q[0].size() < DEPTH || g == 0) vv[0] = 1'b1;
      if (q[0].size() == DEPTH && g == 0) fwr_hits++;
      cyc_chk("fwr", vv, pack4(32'h0F00_0000 + 32'(c), 32'h0F01_0000 + 32'(c), 0, 0), 4'b0);
    end
    chk("fwr.ovf0", 32'(OVERFLOW[0]), 0);
    chk("fwr.hit", 32'(fwr_hits > 0), 1);

    // Mid-stream reset with buffered words everywhere
    do_reset();
    for (int c = 0; c < 3; c++)
      cyc_chk("pre_rst", 4'b1111,
              pack4(32'hDEAD_0000 + 32'(c), 32'hDEAD_0100 + 32'(c),
                    32'hDEAD_0200 + 32'(c), 32'hDEAD_0300 + 32'(c)), 4'b0);
    #2;
    RESET = 1'b1; IN_VALID = 0; IN_VALUE = 0; OVERFLOW_CLEAR = 0;
    #1;
    chk("mid_rst.valid", 32'(OUT_VALID), 0);
    chk("mid_rst.value", OUT_VALUE, 0);
    chk("mid_rst.chan",  32'(OUT_CHANNEL), 0);
    m_reset();
    @(negedge CLK);
    RESET = 1'b0;
    drive_edge(4'b1111, pack4(32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003), 4'b0);
    cmp_model("post_rst0");
    cyc_chk("post_rst1", 4'b0000, 128'h0, 4'b0);
    chk("post_rst.first_chan", 32'(OUT_CHANNEL), 0);
    chk("post_rst.first_val", OUT_VALUE, 32'h5000_0000);
    for (int c = 0; c < 10; c++) begin
      cyc_chk("post_rst", 4'b0000, 128'h0, 4'b0);
      if (OUT_VALID) chk("post_rst.no_stale", 32'(OUT_VALUE[31:16] == 16'hDEAD), 0);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      vv = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) vv = 4'b0;
      dd = {$urandom, $urandom, $urandom, $urandom};
      cyc_chk("rand", vv, dd, ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/signal_arbiter.md
SIGNAL_ARBITER -- requirements
Module: signal_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width of each channel VALUE.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning the number of input channels (2..16).
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning per-channel FIFO depth (power of two, >=2).
REQ-004 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 IN_VALUE  input  CHANNELS*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
REQ-007 IN_VALID  input  CHANNELS  channel i data qualifier; no backpressure exists toward sources.
REQ-008 OUT_VALUE  output  WIDTH  arbitrated data word.
REQ-009 OUT_VALID  output  1  OUT_VALUE qualifier; consumer always accepts.
REQ-010 OUT_CHANNEL  output  $clog2(CHANNELS)  index of the channel that produced OUT_VALUE.
REQ-011 OVERFLOW  output  CHANNELS  sticky per-channel drop flag.
REQ-012 OVERFLOW_CLEAR  input  CHANNELS  per-channel clear of OVERFLOW.

Function
REQ-013 Each cycle with IN_VALID[i]=1 the block SHALL write IN_VALUE slice i into FIFO i.
REQ-014 A write to a full FIFO i SHALL be accepted if FIFO i is granted (read) in the same cycle; otherwise the word SHALL be dropped and OVERFLOW[i] set.
REQ-015 OVERFLOW[i] SHALL stay 1 until OVERFLOW_CLEAR[i]=1; a simultaneous drop and clear SHALL leave OVERFLOW[i]=1.
REQ-016 The arbiter SHALL grant at most one non-empty FIFO per cycle, searching round-robin from pointer PTR upward with wrap-around at CHANNELS-1 -> 0.
REQ-017 After a grant to channel g, PTR SHALL become (g+1) mod CHANNELS; with no grant PTR SHALL hold.
REQ-018 The granted word SHALL appear on OUT_VALUE with OUT_VALID=1 and OUT_CHANNEL=g in the cycle after the grant (registered output).
REQ-019 With no grant, OUT_VALID SHALL be 0 and OUT_VALUE/OUT_CHANNEL SHALL hold their last values.
REQ-020 Latency from an IN_VALID sample into an empty FIFO to OUT_VALID SHALL be exactly 2 cycles when no other channel competes.
REQ-021 A word written in cycle t SHALL NOT be granted in cycle t (no write-through).
REQ-022 Per-channel order SHALL be preserved; with all channels continuously non-empty each channel SHALL receive exactly one grant per CHANNELS cycles.

Reset
REQ-023 RESET=1 SHALL asynchronously empty all FIFOs, set PTR=0, and drive OUT_VALID=0, OUT_VALUE=0, OUT_CHANNEL=0, OVERFLOW=0.
REQ-024 RESET asserted mid-stream SHALL discard all buffered words; no word buffered before RESET SHALL appear afterwards.
REQ-025 The first rising edge with RESET=0 SHALL sample IN_VALID normally.

Configuration
REQ-026 With macro SIGNAL_ARBITER_DROP_CNT_EN defined, the block SHALL add output DROP_CNT (CHANNELS*16 bits), per-channel saturating counters of dropped words, reset to 0, cleared together with OVERFLOW_CLEAR[i] (clear wins over increment).
REQ-027 Without SIGNAL_ARBITER_DROP_CNT_EN, the DROP_CNT port and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-028 Package signal_arbiter_pkg SHALL hold the default WIDTH/CHANNELS/DEPTH constants, the drop-counter width constant (16) and a function computing the round-robin grant index.
REQ-029 Per-channel buffering SHALL be one sub-module, signal_fifo (DEPTH words, write/read/full/empty, async reset), instantiated CHANNELS times.

Verification
REQ-030 Single channel: IN_VALID[2]=1, value 0xA5A5_0001 at cycle 5 -> OUT_VALID=1, OUT_VALUE=0xA5A5_0001, OUT_CHANNEL=2 at cycle 7.
REQ-031 Fairness: all 4 channels send continuously for 40 cycles -> OUT_CHANNEL sequence 0,1,2,3 repeating, each channel's values in order, OVERFLOW stays 0.
REQ-032 Overflow: channel 1 sends 12 words back-to-back while channels 0,2,3 also send continuously (DEPTH=4) -> OVERFLOW[1]=1, dropped words never output; with macro DROP_CNT[1] equals exact drop count.
REQ-033 Full-with-read: FIFO 0 full and granted while IN_VALID[0]=1 -> word accepted, OVERFLOW[0] stays 0.
REQ-034 Mid-stream reset: RESET pulsed while FIFOs hold 3 words each -> OUT_VALID=0 immediately, no pre-reset word ever appears, PTR restarts at channel 0.
REQ-035 Clear collision: OVERFLOW_CLEAR[3]=1 in the same cycle as a drop on channel 3 -> OVERFLOW[3]=1 next cycle; clear alone -> OVERFLOW[3]=0.
